baud_gen_frac: RTL

- Runtime-programmable fractional baud generator, successor to the fixed-rate UART baud generator.
- Produces an oversample tick (`os_tick`) and a bit tick (`baud_tick`) from one clock.
- The divisor is loaded at run time and has an integer part and a fractional part, so any baud rate can be hit without per-rate hard-coded tables.
- Feeds UART RX (oversampled, mid-bit aligned via `start`) and UART TX (`baud_tick` only).

---
 rtl/baud_gen_frac.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/baud_gen_frac.sv
// Runtime-programmable fractional baud generator: a prescaler with a fractional
// accumulator produces os_tick; a phase counter divides that down to baud_tick.
module baud_gen_frac #(
  parameter int INT_WIDTH    = 16,
  parameter int FRAC_WIDTH   = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int DEFAULT_INT  = 27,
  parameter int DEFAULT_FRAC = 2,
  localparam int PH_W        = $clog2(OVERSAMPLE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  div_load,
  input  logic [INT_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  input  logic                  start,
  output logic                  os_tick,
  output logic                  baud_tick,
  output logic [PH_W-1:0]       os_phase
);

  // The period can be int+carry, so it needs one bit more than the divisor.
  localparam int P_W = INT_WIDTH + 1;

  localparam logic [INT_WIDTH-1:0]  RST_INT  = (DEFAULT_INT < 2) ? INT_WIDTH'(2) : INT_WIDTH'(DEFAULT_INT);
  localparam logic [FRAC_WIDTH-1:0] RST_FRAC = FRAC_WIDTH'(DEFAULT_FRAC);
  localparam logic [PH_W-1:0]       PH_HALF  = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0]       PH_LAST  = PH_W'(OVERSAMPLE - 1);

  function automatic logic [INT_WIDTH-1:0] clamp_int(input logic [INT_WIDTH-1:0] value);
    if (value < INT_WIDTH'(2)) begin
      clamp_int = INT_WIDTH'(2);
    end else begin
      clamp_int = value;
    end
  endfunction

  logic [INT_WIDTH-1:0]  shadow_int_r,  shadow_int_s;
  logic [FRAC_WIDTH-1:0] shadow_frac_r, shadow_frac_s;
  logic [P_W-1:0]        cnt_r,    cnt_s;
  logic [P_W-1:0]        period_r, period_s;
  logic [FRAC_WIDTH-1:0] acc_r,    acc_s;
  logic [PH_W-1:0]       phase_r,  phase_s;
  logic                  os_tick_r,   os_tick_s;
  logic                  baud_tick_r, baud_tick_s;

  logic [INT_WIDTH-1:0]  load_int_s;
  logic [INT_WIDTH-1:0]  eff_int_s;
  logic [FRAC_WIDTH-1:0] eff_frac_s;
  logic [FRAC_WIDTH:0]   acc_sum_s;
  logic [P_W-1:0]        wrap_period_s;
  logic                  wrap_s;

  // Divisor that becomes active at a wrap or start; a same-cycle load is taken directly.
  always_comb begin
    load_int_s    = clamp_int(div_int);
    eff_int_s     = shadow_int_r;
    eff_frac_s    = shadow_frac_r;
    if (div_load) begin
      eff_int_s  = load_int_s;
      eff_frac_s = div_frac;
    end else begin
      eff_int_s  = shadow_int_r;
      eff_frac_s = shadow_frac_r;
    end
    wrap_s        = (cnt_r == (period_r - P_W'(1)));
    acc_sum_s     = {1'b0, acc_r} + {1'b0, eff_frac_s};
    wrap_period_s = {1'b0, eff_int_s} + {{INT_WIDTH{1'b0}}, acc_sum_s[FRAC_WIDTH]};
  end

  // Next-state: start resyncs mid-bit and beats a coincident wrap; enable gates counting.
  always_comb begin
    shadow_int_s  = shadow_int_r;
    shadow_frac_s = shadow_frac_r;
    cnt_s         = cnt_r;
    period_s      = period_r;
    acc_s         = acc_r;
    phase_s       = phase_r;
    os_tick_s     = 1'b0;
    baud_tick_s   = 1'b0;

    if (div_load) begin
      shadow_int_s  = load_int_s;
      shadow_frac_s = div_frac;
    end else begin
      shadow_int_s  = shadow_int_r;
      shadow_frac_s = shadow_frac_r;
    end

    if (start) begin
      cnt_s    = {P_W{1'b0}};
      acc_s    = {FRAC_WIDTH{1'b0}};
      period_s = {1'b0, eff_int_s};
      phase_s  = PH_HALF;
    end else if (enable) begin
      if (wrap_s) begin
        cnt_s       = {P_W{1'b0}};
        os_tick_s   = 1'b1;
        acc_s       = acc_sum_s[FRAC_WIDTH-1:0];
        period_s    = wrap_period_s;
        phase_s     = phase_r + PH_W'(1);
        baud_tick_s = (phase_r == PH_LAST);
      end else begin
        cnt_s = cnt_r + P_W'(1);
      end
    end else begin
      cnt_s   = cnt_r;
      acc_s   = acc_r;
      phase_s = phase_r;
    end
  end

  // State register with synchronous reset to the default divisor.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_int_r  <= RST_INT;
      shadow_frac_r <= RST_FRAC;
      cnt_r         <= {P_W{1'b0}};
      period_r      <= {1'b0, RST_INT};
      acc_r         <= {FRAC_WIDTH{1'b0}};
      phase_r       <= {PH_W{1'b0}};
      os_tick_r     <= 1'b0;
      baud_tick_r   <= 1'b0;
    end else begin
      shadow_int_r  <= shadow_int_s;
      shadow_frac_r <= shadow_frac_s;
      cnt_r         <= cnt_s;
      period_r      <= period_s;
      acc_r         <= acc_s;
      phase_r       <= phase_s;
      os_tick_r     <= os_tick_s;
      baud_tick_r   <= baud_tick_s;
    end
  end

  assign os_tick   = os_tick_r;
  assign baud_tick = baud_tick_r;
  assign os_phase  = phase_r;

endmodule
